// File: rtl/os_cache_sequencer_pkg.sv
// Shared types for the output-stationary cache sequencer: cache command codes, FSM states, defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package os_cache_pkg;

    localparam int WA_BITS_DEF = 8;
    localparam int P_BITS_DEF  = 16;
    localparam int WA_ROWS_DEF = 256;
    localparam int P_ROWS_DEF  = 32;

    // Command codes understood by the cache's 3-bit state input.
    typedef enum logic [2:0] {
        CS_LOAD_W  = 3'b000,
        CS_LOAD_A  = 3'b001,
        CS_SEND_W  = 3'b010,
        CS_SEND_A  = 3'b011,
        CS_SEND_WA = 3'b100,
        CS_LOAD_P  = 3'b101,
        CS_SEND_P  = 3'b110,
        CS_IDLE    = 3'b111
    } cache_state_e;

    // Sequencer job phases.
    typedef enum logic [2:0] {
        SQ_IDLE    = 3'd0,
        SQ_CLR     = 3'd1,
        SQ_LOAD_W  = 3'd2,
        SQ_LOAD_A  = 3'd3,
        SQ_STREAM  = 3'd4,
        SQ_LOAD_P  = 3'd5,
        SQ_DRAIN_P = 3'd6,
        SQ_DONE    = 3'd7
    } seq_state_e;

    // Saturate a row-count-minus-one at the last usable row index.
    function automatic logic [7:0] clamp_len(input logic [7:0] len, input logic [7:0] max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/os_cache_sequencer_if.sv
// Bundles job control, upstream W/A stream, GLB psum stream and cache command bus of the sequencer.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both upstream streams; cache side is command-only.
interface os_cache_sequencer_if
    import os_cache_pkg::*;
#(
    parameter int WA_BITS = WA_BITS_DEF,
    parameter int P_BITS  = P_BITS_DEF
);
    logic               w_start;
    logic [7:0]         w_len_wa;
    logic [7:0]         w_len_p;
    logic               w_src_valid;
    logic [WA_BITS-1:0] w_src_data;
    logic               r_src_ready;
    logic               w_glb_valid;
    logic [P_BITS-1:0]  w_glb_data;
    logic               r_glb_ready;
    logic               r_cache_ready;
    logic [2:0]         r_state;
    logic [WA_BITS-1:0] r_bus_in;
    logic [P_BITS-1:0]  r_glb_out;
    logic [7:0]         r_w_addr;
    logic [7:0]         r_a_addr;
    logic               r_pe_valid;
    logic               r_psum_valid;
    logic               r_busy;
    logic               r_done;

    // Sequencer side.
    modport master (
        input  w_start, w_len_wa, w_len_p,
        input  w_src_valid, w_src_data, w_glb_valid, w_glb_data,
        output r_src_ready, r_glb_ready,
        output r_cache_ready, r_state, r_bus_in, r_glb_out, r_w_addr, r_a_addr,
        output r_pe_valid, r_psum_valid, r_busy, r_done
    );

    // Environment side: job issuer, upstream sources and cache.
    modport slave (
        output w_start, w_len_wa, w_len_p,
        output w_src_valid, w_src_data, w_glb_valid, w_glb_data,
        input  r_src_ready, r_glb_ready,
        input  r_cache_ready, r_state, r_bus_in, r_glb_out, r_w_addr, r_a_addr,
        input  r_pe_valid, r_psum_valid, r_busy, r_done
    );

endinterface

// File: rtl/os_cache_sequencer.sv
// Runs one cache job per start: clear, load N weights + N activations, stream pairs, load/drain M psums.
// Latency: every cache command is registered and appears 1 cycle after its cause; pe/psum valid 1 cycle later.
// Backpressure: upstream stalls (valid=0) issue cache no-ops; the cache side itself never stalls.
module os_cache_sequencer
    import os_cache_pkg::*;
#(
    parameter int WA_BITS = WA_BITS_DEF,
    parameter int P_BITS  = P_BITS_DEF,
    parameter int WA_ROWS = WA_ROWS_DEF,
    parameter int P_ROWS  = P_ROWS_DEF
) (
    input  logic                 w_clk,
    input  logic                 w_rst_n,
    os_cache_sequencer_if.master sq
);

    localparam logic [7:0] WA_LAST = 8'(WA_ROWS - 1);
    localparam logic [7:0] P_LAST  = 8'(P_ROWS - 1);

    seq_state_e         fsm_q, fsm_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [7:0]         len_wa_q, len_wa_d;
    logic [7:0]         len_p_q, len_p_d;
    cache_state_e       cs_q, cs_d;
    logic [7:0]         w_addr_q, w_addr_d;
    logic [7:0]         a_addr_q, a_addr_d;
    logic [WA_BITS-1:0] bus_q, bus_d;
    logic [P_BITS-1:0]  glb_q, glb_d;
    logic               cache_rdy_q, cache_rdy_d;
    logic               pe_vld_q, psum_vld_q;
    logic               done_q, done_d;

    // Sequencer state, counters and registered cache-side outputs.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            fsm_q       <= SQ_IDLE;
            cnt_q       <= '0;
            len_wa_q    <= '0;
            len_p_q     <= '0;
            cs_q        <= CS_IDLE;
            w_addr_q    <= '0;
            a_addr_q    <= '0;
            bus_q       <= '0;
            glb_q       <= '0;
            cache_rdy_q <= 1'b0;
            pe_vld_q    <= 1'b0;
            psum_vld_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            cnt_q       <= cnt_d;
            len_wa_q    <= len_wa_d;
            len_p_q     <= len_p_d;
            cs_q        <= cs_d;
            w_addr_q    <= w_addr_d;
            a_addr_q    <= a_addr_d;
            bus_q       <= bus_d;
            glb_q       <= glb_d;
            cache_rdy_q <= cache_rdy_d;
            // The cache answers a send command one cycle after it sees it.
            pe_vld_q    <= (cs_q == CS_SEND_WA);
            psum_vld_q  <= (cs_q == CS_SEND_P);
            done_q      <= done_d;
        end
    end

    // Next phase and next cache command; no-op unless a handshake or a streaming phase produces one.
    always_comb begin
        fsm_d    = fsm_q;
        cnt_d    = cnt_q;
        len_wa_d = len_wa_q;
        len_p_d  = len_p_q;
        cs_d     = CS_IDLE;
        w_addr_d = w_addr_q;
        a_addr_d = a_addr_q;
        bus_d    = bus_q;
        glb_d    = glb_q;
        done_d   = 1'b0;

        case (fsm_q)
            SQ_IDLE: begin
                if (sq.w_start) begin
                    len_wa_d = clamp_len(sq.w_len_wa, WA_LAST);
                    len_p_d  = clamp_len(sq.w_len_p, P_LAST);
                    cnt_d    = '0;
                    fsm_d    = SQ_CLR;
                end
            end
            SQ_CLR: begin
                cnt_d = '0;
                fsm_d = SQ_LOAD_W;
            end
            SQ_LOAD_W: begin
                if (sq.w_src_valid) begin
                    cs_d     = CS_LOAD_W;
                    w_addr_d = cnt_q;
                    bus_d    = sq.w_src_data;
                    if (cnt_q == len_wa_q) begin
                        cnt_d = '0;
                        fsm_d = SQ_LOAD_A;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            SQ_LOAD_A: begin
                if (sq.w_src_valid) begin
                    cs_d     = CS_LOAD_A;
                    a_addr_d = cnt_q;
                    bus_d    = sq.w_src_data;
                    if (cnt_q == len_wa_q) begin
                        cnt_d = '0;
                        fsm_d = SQ_STREAM;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            SQ_STREAM: begin
                cs_d     = CS_SEND_WA;
                w_addr_d = cnt_q;
                a_addr_d = cnt_q;
                if (cnt_q == len_wa_q) begin
                    cnt_d = '0;
                    fsm_d = SQ_LOAD_P;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            SQ_LOAD_P: begin
                if (sq.w_glb_valid) begin
                    cs_d     = CS_LOAD_P;
                    w_addr_d = cnt_q;
                    glb_d    = sq.w_glb_data;
                    if (cnt_q == len_p_q) begin
                        cnt_d = '0;
                        fsm_d = SQ_DRAIN_P;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            SQ_DRAIN_P: begin
                cs_d     = CS_SEND_P;
                w_addr_d = cnt_q;
                if (cnt_q == len_p_q) begin
                    cnt_d = '0;
                    fsm_d = SQ_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            SQ_DONE: begin
                // The last psum valid is the one with no drain command still behind it.
                if (psum_vld_q && (cs_q != CS_SEND_P)) begin
                    done_d = 1'b1;
                    fsm_d  = SQ_IDLE;
                end
            end
            default: fsm_d = SQ_IDLE;
        endcase

        // Cache clears on exactly the single cycle spent in CLR.
        cache_rdy_d = (fsm_d != SQ_CLR);
    end

    assign sq.r_src_ready   = (fsm_q == SQ_LOAD_W) || (fsm_q == SQ_LOAD_A);
    assign sq.r_glb_ready   = (fsm_q == SQ_LOAD_P);
    assign sq.r_busy        = (fsm_q != SQ_IDLE);
    assign sq.r_done        = done_q;
    assign sq.r_cache_ready = cache_rdy_q;
    assign sq.r_state       = cs_q;
    assign sq.r_bus_in      = bus_q;
    assign sq.r_glb_out     = glb_q;
    assign sq.r_w_addr      = w_addr_q;
    assign sq.r_a_addr      = a_addr_q;
    assign sq.r_pe_valid    = pe_vld_q;
    assign sq.r_psum_valid  = psum_vld_q;

endmodule

// File: tb/tb_os_cache_sequencer.sv
// Scoreboard bench for os_cache_sequencer: drivers push expected cache commands/outputs, a monitor pops and compares.
// Latency: n/a.
// Backpressure: exercised via stalled upstream valid.
module tb_os_cache_sequencer;
    import os_cache_pkg::*;

    logic w_clk = 1'b0;
    logic w_rst_n = 1'b0;
    always #5 w_clk = ~w_clk;

    os_cache_sequencer_if #(.WA_BITS(8), .P_BITS(16)) sq ();

    os_cache_sequencer #(.WA_BITS(8), .P_BITS(16), .WA_ROWS(256), .P_ROWS(32)) dut (
        .w_clk   (w_clk),
        .w_rst_n (w_rst_n),
        .sq      (sq)
    );

    typedef struct {
        logic [2:0]  cs;
        logic [7:0]  wa;
        logic [7:0]  aa;
        logic [15:0] dat;
    } cmd_t;

    cmd_t        cmd_q[$];
    logic [15:0] pair_q[$];
    logic [15:0] psum_q[$];
    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    // Behavioural cache: memories written by the commands, outputs registered one cycle after a send.
    logic [7:0]  wmem [256];
    logic [7:0]  amem [256];
    logic [15:0] pmem [32];
    logic [7:0]  pe_w, pe_a;
    logic [15:0] p_out;

    always @(posedge w_clk) begin
        if (!sq.r_cache_ready) begin
            for (int i = 0; i < 256; i++) begin
                wmem[i] <= 8'h0;
                amem[i] <= 8'h0;
            end
            for (int i = 0; i < 32; i++) pmem[i] <= 16'h0;
        end else begin
            case (sq.r_state)
                3'b000: wmem[sq.r_w_addr] <= sq.r_bus_in;
                3'b001: amem[sq.r_a_addr] <= sq.r_bus_in;
                3'b100: begin
                    pe_w <= wmem[sq.r_w_addr];
                    pe_a <= amem[sq.r_a_addr];
                end
                3'b101: pmem[sq.r_w_addr[4:0]] <= sq.r_glb_out;
                3'b110: p_out <= pmem[sq.r_w_addr[4:0]];
                default: ;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every non-idle command, pe output and psum output is matched against the queues.
    always @(negedge w_clk) begin
        cmd_t e, a;
        if (w_rst_n) begin
            if (sq.r_state != 3'b111) begin
                if (cmd_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_cmd actual=state %b waddr %0d aaddr %0d required=none",
                             sq.r_state, sq.r_w_addr, sq.r_a_addr);
                end else begin
                    e = cmd_q.pop_front();
                    a.cs  = sq.r_state;
                    a.wa  = (e.cs == CS_LOAD_A) ? 8'h0 : sq.r_w_addr;
                    a.aa  = (e.cs == CS_LOAD_A || e.cs == CS_SEND_WA) ? sq.r_a_addr : 8'h0;
                    a.dat = (e.cs == CS_LOAD_W || e.cs == CS_LOAD_A) ? {8'h0, sq.r_bus_in} :
                            (e.cs == CS_LOAD_P) ? sq.r_glb_out : 16'h0;
                    chk("cmd", {a.cs, a.wa, a.aa, a.dat}, {e.cs, e.wa, e.aa, e.dat});
                end
            end
            if (sq.r_pe_valid) begin
                if (pair_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_pe_valid actual=%0h required=none", {pe_w, pe_a});
                end else chk("pe_pair", {pe_w, pe_a}, pair_q.pop_front());
            end
            if (sq.r_psum_valid) begin
                if (psum_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_psum_valid actual=%0h required=none", p_out);
                end else chk("psum", p_out, psum_q.pop_front());
            end
            if (sq.r_done) done_cnt++;
        end
    end

    task automatic push_cmd(input logic [2:0] cs, input logic [7:0] wa, input logic [7:0] aa,
                            input logic [15:0] d);
        cmd_t c;
        c.cs = cs; c.wa = wa; c.aa = aa; c.dat = d;
        cmd_q.push_back(c);
    endtask

    // One upstream W/A beat, optionally preceded by a one-cycle stall; returns 1 time unit after the handshake edge.
    task automatic src_beat(input logic [7:0] d, input bit stall);
        int k = 0;
        if (stall) begin
            sq.w_src_valid = 1'b0;
            @(posedge w_clk); #1;
        end
        sq.w_src_valid = 1'b1;
        sq.w_src_data  = d;
        while (!sq.r_src_ready && k < 2000) begin @(negedge w_clk); k++; end
        if (!sq.r_src_ready) begin
            total++; bad++;
            $display("FAIL src_ready_timeout actual=0 required=1");
        end
        @(posedge w_clk); #1;
        sq.w_src_valid = 1'b0;
    endtask

    task automatic glb_beat(input logic [15:0] d);
        int k = 0;
        sq.w_glb_valid = 1'b1;
        sq.w_glb_data  = d;
        while (!sq.r_glb_ready && k < 2000) begin @(negedge w_clk); k++; end
        if (!sq.r_glb_ready) begin
            total++; bad++;
            $display("FAIL glb_ready_timeout actual=0 required=1");
        end
        @(posedge w_clk); #1;
        sq.w_glb_valid = 1'b0;
    endtask

    task automatic run_job(input int n, input logic [7:0] lenp, input logic [7:0] wbase,
                           input logic [7:0] abase, input bit toggle, input bit start_in_a,
                           input bit abort);
        int m;
        int d0;
        int k;
        logic [7:0]  wv, av;
        logic [15:0] pv;
        m = (lenp > 8'd31) ? 32 : int'(lenp) + 1;
        @(posedge w_clk); #1;
        sq.w_start  = 1'b1;
        sq.w_len_wa = 8'(n - 1);
        sq.w_len_p  = lenp;
        @(posedge w_clk); #1;
        sq.w_start = 1'b0;
        chk("clr_cache_ready", sq.r_cache_ready, 0);
        chk("busy_after_start", sq.r_busy, 1);
        @(posedge w_clk); #1;
        chk("cache_ready_after_clr", sq.r_cache_ready, 1);

        for (int i = 0; i < n; i++) begin
            wv = 8'(wbase + 8'(i));
            src_beat(wv, toggle && (i % 2 == 1));
            push_cmd(CS_LOAD_W, 8'(i), 8'h0, {8'h0, wv});
        end
        for (int i = 0; i < n; i++) begin
            av = 8'(abase + 8'(i));
            if (start_in_a && i == n / 2) sq.w_start = 1'b1;
            src_beat(av, toggle && (i % 2 == 1));
            sq.w_start = 1'b0;
            push_cmd(CS_LOAD_A, 8'h0, 8'(i), {8'h0, av});
        end
        chk("src_ready_drop", sq.r_src_ready, 0);
        for (int i = 0; i < n; i++) begin
            push_cmd(CS_SEND_WA, 8'(i), 8'(i), 16'h0);
            pair_q.push_back({8'(wbase + 8'(i)), 8'(abase + 8'(i))});
        end

        if (abort) begin
            k = 0;
            while (sq.r_state != 3'b100 && k < 100) begin @(negedge w_clk); k++; end
            chk("reached_stream", sq.r_state, 3'b100);
            #2 w_rst_n = 1'b0;
            #1;
            chk("abort_state", sq.r_state, 3'b111);
            chk("abort_cache_ready", sq.r_cache_ready, 0);
            chk("abort_flags", {sq.r_src_ready, sq.r_glb_ready, sq.r_busy, sq.r_done,
                                sq.r_pe_valid, sq.r_psum_valid}, 0);
            chk("abort_bus", {sq.r_w_addr, sq.r_a_addr, sq.r_bus_in, sq.r_glb_out}, 0);
            cmd_q.delete();
            pair_q.delete();
            psum_q.delete();
            repeat (2) @(posedge w_clk);
            #1 w_rst_n = 1'b1;
            @(posedge w_clk); #1;
            chk("post_abort_state", sq.r_state, 3'b111);
            chk("post_abort_idle", {sq.r_busy, sq.r_src_ready, sq.r_cache_ready}, 3'b001);
            return;
        end

        for (int i = 0; i < m; i++) begin
            pv = 16'h1000 + 16'(i * 3);
            glb_beat(pv);
            push_cmd(CS_LOAD_P, 8'(i), 8'h0, pv);
        end
        chk("glb_ready_drop", sq.r_glb_ready, 0);
        for (int i = 0; i < m; i++) begin
            push_cmd(CS_SEND_P, 8'(i), 8'h0, 16'h0);
            psum_q.push_back(16'h1000 + 16'(i * 3));
        end

        d0 = done_cnt;
        k = 0;
        while (done_cnt == d0 && k < 3000) begin @(negedge w_clk); k++; end
        chk("done_seen", (done_cnt != d0), 1);
        chk("busy_at_done", sq.r_busy, 0);
        repeat (3) @(negedge w_clk);
        chk("done_once", done_cnt - d0, 1);
        chk("queues_drained", cmd_q.size() + pair_q.size() + psum_q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sq.w_start     = 1'b1;   // start held during reset must be ignored
        sq.w_len_wa    = 8'd3;
        sq.w_len_p     = 8'd1;
        sq.w_src_valid = 1'b0;
        sq.w_src_data  = 8'h0;
        sq.w_glb_valid = 1'b0;
        sq.w_glb_data  = 16'h0;
        repeat (2) @(posedge w_clk);
        #1;
        chk("rst_state", sq.r_state, 3'b111);
        chk("rst_cache_ready", sq.r_cache_ready, 0);
        chk("rst_flags", {sq.r_src_ready, sq.r_glb_ready, sq.r_busy, sq.r_done,
                          sq.r_pe_valid, sq.r_psum_valid}, 0);
        chk("rst_bus", {sq.r_w_addr, sq.r_a_addr, sq.r_bus_in, sq.r_glb_out}, 0);
        w_rst_n   = 1'b1;
        sq.w_start = 1'b0;
        @(posedge w_clk); #1;
        chk("idle_after_rst", {sq.r_busy, sq.r_cache_ready, sq.r_state}, {1'b0, 1'b1, 3'b111});

        // N=4, W=1..4, A=5..8, M=3, no stalls
        run_job(4, 8'd2, 8'd1, 8'd5, 1'b0, 1'b0, 1'b0);
        // reset in the middle of STREAM
        run_job(4, 8'd2, 8'd1, 8'd5, 1'b0, 1'b0, 1'b1);
        // same data with valid toggling
        run_job(4, 8'd2, 8'd1, 8'd5, 1'b1, 1'b0, 1'b0);
        // psum length clamped to 32 rows
        run_job(4, 8'd40, 8'd1, 8'd5, 1'b0, 1'b0, 1'b0);
        // full 256-row weight/activation job
        run_job(256, 8'd0, 8'd0, 8'h80, 1'b0, 1'b0, 1'b0);
        // start pulsed during LOAD_A, then a normal back-to-back job
        run_job(4, 8'd2, 8'd9, 8'd20, 1'b0, 1'b1, 1'b0);
        run_job(3, 8'd1, 8'd40, 8'd50, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
